// File: rtl/shift_engine.sv
// shift_engine: multi-mode shift register (logical, arithmetic, rotate, serial-fill).
// It loads an N-bit word and shifts it one position per clock for a programmed amount.
// busy and done form the handshake with the controlling FSM.
// Optional feature: define SHIFT_ENGINE_ABORT_EN to add the abort input.
module shift_engine #(
  parameter int unsigned N     = 7,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHIFT_ENGINE_ABORT_EN
  input  logic             abort,
`endif
  input  logic             load_en,
  input  logic [N-1:0]     data_in,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [N-1:0]     data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SER = 2'b11;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_d;
  logic [AMT_W-1:0] cnt, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [N-1:0]     data_d;
  logic             sout_d;
  logic             done_d;
  logic             fill;
  logic             last_shift;
  logic             abort_req;

`ifdef SHIFT_ENGINE_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_shift = (cnt == AMT_W'(1));
  assign busy       = (state == SHIFT);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (!load_en && start && (amount != '0)) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort_req || last_shift) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fill bit entering the vacated end for the latched direction and mode
  always_comb begin
    fill = 1'b0;
    if (!dir_q) begin
      case (mode_q)
        MODE_LOG: fill = 1'b0;
        MODE_ARI: fill = data_out[N-1];
        MODE_ROT: fill = data_out[0];
        MODE_SER: fill = serial_in;
        default:  fill = 1'b0;
      endcase
    end else begin
      case (mode_q)
        MODE_ROT: fill = data_out[N-1];
        MODE_SER: fill = serial_in;
        default:  fill = 1'b0;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    data_d = data_out;
    sout_d = serial_out;
    done_d = 1'b0;
    cnt_d  = cnt;
    dir_d  = dir_q;
    mode_d = mode_q;
    case (state)
      IDLE: begin
        if (load_en) begin
          data_d = data_in;
        end else if (start) begin
          if (amount == '0) begin
            done_d = 1'b1;
          end else begin
            dir_d  = dir;
            mode_d = mode;
            cnt_d  = amount;
          end
        end
      end
      SHIFT: begin
        if (abort_req) begin
          cnt_d = '0;
        end else begin
          if (!dir_q) begin
            data_d = {fill, data_out[N-1:1]};
            sout_d = data_out[0];
          end else begin
            data_d = {data_out[N-2:0], fill};
            sout_d = data_out[N-1];
          end
          cnt_d  = cnt - AMT_W'(1);
          done_d = last_shift;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      serial_out <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      dir_q      <= 1'b0;
      mode_q     <= 2'b00;
    end else begin
      data_out   <= data_d;
      serial_out <= sout_d;
      done       <= done_d;
      cnt        <= cnt_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
    end
  end

endmodule

// File: tb/tb_shift_engine.sv
// Directed self-checking bench for shift_engine (N = 7, AMT_W = 3).
// Define SHIFT_ENGINE_ABORT_EN to also exercise the abort port.
module tb_shift_engine;

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic       load_en;
  logic [6:0] data_in;
  logic       start;
  logic       dir;
  logic [1:0] mode;
  logic [2:0] amount;
  logic       serial_in;
  logic [6:0] data_out;
  logic       serial_out;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  shift_engine #(.N(7), .AMT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SHIFT_ENGINE_ABORT_EN
    .abort      (abort),
`endif
    .load_en    (load_en),
    .data_in    (data_in),
    .start      (start),
    .dir        (dir),
    .mode       (mode),
    .amount     (amount),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [6:0] v);
    load_en = 1'b1;
    data_in = v;
    step();
    load_en = 1'b0;
  endtask

  task automatic go(input logic d, input logic [1:0] m, input logic [2:0] a);
    start  = 1'b1;
    dir    = d;
    mode   = m;
    amount = a;
    step();
    start  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; load_en = 1'b0; data_in = '0; start = 1'b0;
    dir = 1'b0; mode = 2'b00; amount = '0; serial_in = 1'b0;
    step();
    step();
    chk_d("rst_data", data_out, 7'b0000000);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_sout", serial_out, 1'b0);
    rst_n = 1'b1;

    // Logical right by 3
    load(7'b1011001);
    chk_d("lsr_load", data_out, 7'b1011001);
    go(1'b0, 2'b00, 3'd3);
    chk_b("lsr_busy_e0", busy, 1'b1);
    chk_d("lsr_e0", data_out, 7'b1011001);
    step();
    chk_d("lsr_e1", data_out, 7'b0101100);
    chk_b("lsr_sout_e1", serial_out, 1'b1);
    chk_b("lsr_busy_e1", busy, 1'b1);
    step();
    chk_d("lsr_e2", data_out, 7'b0010110);
    chk_b("lsr_busy_e2", busy, 1'b1);
    chk_b("lsr_done_e2", done, 1'b0);
    step();
    chk_d("lsr_e3", data_out, 7'b0001011);
    chk_b("lsr_busy_e3", busy, 1'b0);
    chk_b("lsr_done_e3", done, 1'b1);
    chk_b("lsr_sout_e3", serial_out, 1'b0);
    step();
    chk_b("lsr_done_drop", done, 1'b0);

    // Arithmetic right by 2
    load(7'b1000110);
    go(1'b0, 2'b01, 3'd2);
    step();
    chk_d("asr_e1", data_out, 7'b1100011);
    step();
    chk_d("asr_e2", data_out, 7'b1110001);
    chk_b("asr_sout", serial_out, 1'b1);
    chk_b("asr_done", done, 1'b1);

    // Rotate left by 7 returns the original word, done at latency 8
    load(7'b1000110);
    go(1'b1, 2'b10, 3'd7);
    step();
    chk_d("rol_e1", data_out, 7'b0001101);
    for (int i = 2; i <= 6; i++) begin
      step();
      chk_b("rol_busy_mid", busy, 1'b1);
      chk_b("rol_done_mid", done, 1'b0);
    end
    step();
    chk_d("rol_e7", data_out, 7'b1000110);
    chk_b("rol_done_e7", done, 1'b1);
    chk_b("rol_busy_e7", busy, 1'b0);

    // Serial fill right by 2, then back-to-back start in the done cycle
    load(7'b0000000);
    serial_in = 1'b1;
    go(1'b0, 2'b11, 3'd2);
    step();
    step();
    chk_d("ser_e2", data_out, 7'b1100000);
    chk_b("ser_done", done, 1'b1);
    serial_in = 1'b0;
    go(1'b1, 2'b00, 3'd1);
    chk_b("b2b_busy", busy, 1'b1);
    step();
    chk_d("b2b_lsl", data_out, 7'b1000000);
    chk_b("b2b_done", done, 1'b1);
    chk_b("b2b_sout", serial_out, 1'b1);

    // Load and start during busy are ignored
    load(7'b1011001);
    go(1'b0, 2'b00, 3'd3);
    start = 1'b1; load_en = 1'b1; data_in = 7'b1111111;
    dir = 1'b1; mode = 2'b10; amount = 3'd1;
    step();
    chk_d("prot_e1", data_out, 7'b0101100);
    step();
    step();
    chk_d("prot_e3", data_out, 7'b0001011);
    chk_b("prot_done", done, 1'b1);
    start = 1'b0; load_en = 1'b0;
    step();

    // Zero amount: done after E0, busy never set
    load(7'b0101010);
    go(1'b0, 2'b00, 3'd0);
    chk_b("zero_done", done, 1'b1);
    chk_b("zero_busy", busy, 1'b0);
    chk_d("zero_data", data_out, 7'b0101010);
    step();
    chk_b("zero_done_drop", done, 1'b0);
    chk_b("zero_busy2", busy, 1'b0);

    // Reset mid-shift
    load(7'b1111111);
    go(1'b0, 2'b01, 3'd5);
    step();
    chk_b("mrst_sout_pre", serial_out, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_d("mrst_data", data_out, 7'b0000000);
    chk_b("mrst_sout", serial_out, 1'b0);
    chk_b("mrst_busy", busy, 1'b0);
    chk_b("mrst_done", done, 1'b0);
    step();
    chk_b("mrst_busy2", busy, 1'b0);
    chk_b("mrst_done2", done, 1'b0);

`ifdef SHIFT_ENGINE_ABORT_EN
    // Abort after E2 keeps the partial value and suppresses done
    load(7'b1111111);
    go(1'b1, 2'b00, 3'd5);
    step();
    step();
    chk_d("abt_e2", data_out, 7'b1111100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_d("abt_data", data_out, 7'b1111100);
    chk_b("abt_busy", busy, 1'b0);
    chk_b("abt_done", done, 1'b0);
    step();
    chk_b("abt_done2", done, 1'b0);
    chk_d("abt_hold", data_out, 7'b1111100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised multi-mode shift register, successor to the plain load/shift-right register in the datapath drafts. It loads an N-bit word and, on a start request, shifts it left or right by a programmable number of positions, one position per clock. Modes are logical, arithmetic, rotate and serial-fill. A busy/done handshake lets the control FSM sequence shift operations without counting cycles itself.

## Interface
- N, default 7: data width in bits (N ≥ 2).
- AMT_W, default 3: width of the shift-amount field. Amounts 0 to 2^AMT_W−1 are legal.
- clk  input  1: rising-edge clock.
- rst_n  input  1: reset, synchronous, active-low.
- load_en  input  1: load data_in into the register. Honoured only in IDLE.
- data_in  input  N: parallel load value.
- start  input  1: begin a shift operation. Sampled only in IDLE.
- dir  input  1: 0 = right (toward bit 0), 1 = left. Latched at start.
- mode  input  2: latched at start.
  - 00 = logical.
  - 01 = arithmetic.
  - 10 = rotate.
  - 11 = serial-fill.
- amount  input  AMT_W: number of single-position shifts. Latched at start.
- serial_in  input  1: fill bit for mode 11. Sampled on every shift edge.
- data_out  output  N: register contents.
- serial_out  output  1: last bit shifted out (registered).
- busy  output  1: high while a shift operation is in progress.
- done  output  1: one-cycle pulse when an operation completes.

## Operation
- There are two states, IDLE and SHIFT. The block holds a latched dir, mode and remaining-count cnt (AMT_W bits).
- In IDLE:
  - If load_en = 1: data_out ← data_in. Any start in the same cycle is ignored (load wins).
  - Else if start = 1 and amount = 0: data_out is unchanged, done = 1 next cycle, and the block stays in IDLE.
  - Else if start = 1 and amount > 0: latch dir, mode and amount into cnt, then go to SHIFT.
- In SHIFT, every edge performs one shift and decrements cnt. When cnt = 1, that final edge returns the block to IDLE and sets done for one cycle.
- Shift rules, right (dir = 0):
  - Logical: MSB filled with 0.
  - Arithmetic: MSB replicated.
  - Rotate: old bit 0 enters the MSB.
  - Serial-fill: serial_in enters the MSB.
  - serial_out ← old bit 0.
- Shift rules, left (dir = 1):
  - Logical and arithmetic: LSB filled with 0 (the two modes are identical).
  - Rotate: old MSB enters the LSB.
  - Serial-fill: serial_in enters the LSB.
  - serial_out ← old MSB.
- Amounts greater than N are performed literally. Logical shifts saturate to zero. Rotate wraps modulo N.
- In SHIFT, load_en, start, dir, mode and amount are ignored.
- serial_out changes only on shift edges.
- Reset (rst_n = 0 at an edge), including mid-operation:
  - data_out = 0, serial_out = 0, busy = 0, done = 0.
  - State goes to IDLE and cnt = 0.

## Timing
- Start is accepted at edge E0 with amount k > 0.
- busy = 1 from after E0 through after E(k−1). busy = 0 after Ek.
- data_out is shifted by i positions after edge Ei, for i = 1..k.
- done = 1 for exactly the cycle following Ek.
- Start-to-done latency is k+1 edges.
- With amount = 0, done = 1 for the cycle following E0 and busy stays 0.
- busy is combinationally equivalent to state == SHIFT, which is a registered value.
- A new start may be presented in the same cycle done is high; it is accepted because the block is in IDLE.
- Back-to-back operations have one IDLE cycle between the end of busy and the next busy.

## Configuration
- Macro SHIFT_ENGINE_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort = 1 while in SHIFT moves the block to IDLE at the next edge. No shift occurs on that edge.
  - data_out keeps its partial value, cnt is cleared, and done is NOT pulsed.
  - abort in IDLE has no effect.
  - Reset takes precedence over abort.
- Not defined:
  - The abort port does not exist.
  - Every accepted operation runs to completion.

## Test plan
All scenarios use N = 7 and AMT_W = 3.
- Load 1011001, then start with dir = 0, mode = 00, amount = 3:
  - data_out goes 0101100, 0010110, 0001011.
  - busy is high for 3 cycles and done pulses after E3.
  - serial_out = 0.
- Load 1000110, then start with dir = 0, mode = 01, amount = 2:
  - data_out = 1110001 after E2.
  - serial_out = 1.
- Load 1000110, then start with dir = 1, mode = 10, amount = 7:
  - data_out = 1000110 after E7.
  - done pulses at latency 8 edges.
- Load 0000000, then start with dir = 0, mode = 11, amount = 2, serial_in = 1:
  - data_out = 1100000.
- Busy-state protection and reset:
  - Assert start and load_en with data_in = 1111111 during busy: both are ignored and the operation completes with the expected result.
  - Drop rst_n for one edge mid-shift: all outputs are 0 the next cycle.
  - amount = 0: done pulses after E0 and busy is never set.
- With SHIFT_ENGINE_ABORT_EN defined:
  - Load 1111111, start with dir = 1, mode = 00, amount = 5, and assert abort in the cycle after E2.
  - data_out = 1111100 after abort takes effect.
  - busy = 0 and no done pulse occurs.
